// File: rtl/tlb_ctrl.sv
// tlb_ctrl
// Sequencer and arbiter that sits in front of a set-associative TLB array.
// Two translation requesters share the single lookup/fill port: port 0 is the
// instruction side and port 1 is the data side. Each accepted request runs a
// TLB lookup. A hit is answered straight away. A miss issues a page-walk
// request, and a successful walk fills the TLB using the per-set tree-PLRU
// victim. A walk fault is returned to the requester and nothing is filled.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     per-port request handshake (bit i = port i)
//   req{0,1}_vaddr/pcid virtual address and PCID for each port
//   resp_*              one-cycle response pulse: owner id, paddr, fault
//   tlb_lk_*            lookup strobe out; hit/way/ppn come back one cycle later
//   tlb_fill_*          fill strobe with the victim way and the new entry
//   ptw_req_*           page-walk request handshake
//   ptw_resp_*          page-walk result pulse
module tlb_ctrl #(
    parameter int ADDR    = 64,
    parameter int PAGE    = 12,
    parameter int PCID    = 12,
    parameter int SET_NUM = 8,
    parameter int WAY     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [ADDR-1:0]         req0_vaddr,
    input  logic [ADDR-1:0]         req1_vaddr,
    input  logic [PCID-1:0]         req0_pcid,
    input  logic [PCID-1:0]         req1_pcid,
    output logic                    resp_valid,
    output logic                    resp_id,
    output logic [ADDR-1:0]         resp_paddr,
    output logic                    resp_fault,
    output logic                    tlb_lk_valid,
    output logic [ADDR-PAGE-1:0]    tlb_lk_vpn,
    output logic [PCID-1:0]         tlb_lk_pcid,
    input  logic                    tlb_lk_hit,
    input  logic [$clog2(WAY)-1:0]  tlb_lk_way,
    input  logic [ADDR-PAGE-1:0]    tlb_lk_ppn,
    output logic                    tlb_fill_valid,
    output logic [$clog2(WAY)-1:0]  tlb_fill_way,
    output logic [ADDR-PAGE-1:0]    tlb_fill_vpn,
    output logic [PCID-1:0]         tlb_fill_pcid,
    output logic [ADDR-PAGE-1:0]    tlb_fill_ppn,
    output logic                    ptw_req_valid,
    input  logic                    ptw_req_ready,
    output logic [ADDR-PAGE-1:0]    ptw_req_vpn,
    output logic [PCID-1:0]         ptw_req_pcid,
    input  logic                    ptw_resp_valid,
    input  logic [ADDR-PAGE-1:0]    ptw_resp_ppn,
    input  logic                    ptw_resp_fault
);

    localparam int VPN_W = ADDR - PAGE;
    localparam int SET_W = $clog2(SET_NUM);
    localparam int WAY_W = $clog2(WAY);
    localparam int NODES = WAY - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        WALK_REQ,
        WALK_WAIT,
        FILL
    } state_t;

    state_t state_reg, state_next;

    // Latched request
    logic [ADDR-1:0]  vaddr_reg;
    logic [PCID-1:0]  pcid_reg;
    logic             id_reg;
    logic [VPN_W-1:0] ppn_reg;

    // Round-robin pointer: names the port that wins when both are valid.
    logic rr_ptr_reg;

    // Response registers
    logic             resp_valid_reg;
    logic             resp_id_reg;
    logic [ADDR-1:0]  resp_paddr_reg;
    logic             resp_fault_reg;

    // PLRU state
    logic [NODES-1:0] plru_bits [SET_NUM];
    logic [SET_W-1:0] set_idx;
    logic [NODES-1:0] plru_cur;
    logic [NODES-1:0] plru_wr_data;
    logic             plru_wr_en;
    logic [WAY_W-1:0] victim_way;

    logic [1:0] grant;
    logic       accept;

    // ------------------------------------------------------------------
    // Tree-PLRU helpers. Node n has children 2n+1 (lower half) and 2n+2
    // (upper half). The way number is built MSB first while walking down,
    // so each level consumes one way bit.
    // ------------------------------------------------------------------
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
        logic [WAY_W-1:0] n;
        logic [WAY_W-1:0] w;
        logic             b;
        n = '0;
        w = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b = bits[n];
            w = (w << 1) | WAY_W'(b);
            // The final step may wrap; that node index is never used.
            n = (n << 1) + WAY_W'(1) + WAY_W'(b);
        end
        return w;
    endfunction

    // Point every node on the path to the accessed way at the other half.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] way_sel);
        logic [NODES-1:0] r;
        logic [WAY_W-1:0] n;
        logic [WAY_W-1:0] path;
        logic             b;
        r    = bits;
        n    = '0;
        path = way_sel;
        for (int l = 0; l < WAY_W; l++) begin
            b    = path[WAY_W-1];
            r[n] = ~b;
            path = path << 1;
            n    = (n << 1) + WAY_W'(1) + WAY_W'(b);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration. Grant is a pure function of req_valid and the pointer;
    // it is only exposed as ready while idle and out of reset.
    // ------------------------------------------------------------------
    always_comb begin
        grant[0] = req_valid[0] && (!req_valid[1] || !rr_ptr_reg);
        grant[1] = req_valid[1] && (!req_valid[0] ||  rr_ptr_reg);
    end

    assign req_ready = (state_reg == IDLE && rst_n) ? grant : 2'b00;
    assign accept    = |req_ready;

    // ------------------------------------------------------------------
    // Set selection and PLRU storage
    // ------------------------------------------------------------------
    assign set_idx    = vaddr_reg[PAGE +: SET_W];
    assign plru_cur   = plru_bits[set_idx];
    assign victim_way = plru_victim(plru_cur);

    genvar gi;
    generate
        for (gi = 0; gi < SET_NUM; gi++) begin : g_plru
            logic [NODES-1:0] bits_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bits_reg <= '0;
                end else if (plru_wr_en && set_idx == SET_W'(gi)) begin
                    bits_reg <= plru_wr_data;
                end
            end

            assign plru_bits[gi] = bits_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, strobes and PLRU write
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        tlb_lk_valid   = 1'b0;
        ptw_req_valid  = 1'b0;
        tlb_fill_valid = 1'b0;
        plru_wr_en     = 1'b0;
        plru_wr_data   = plru_cur;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                tlb_lk_valid = 1'b1;
                state_next   = CHECK;
            end
            CHECK: begin
                if (tlb_lk_hit) begin
                    plru_wr_en   = 1'b1;
                    plru_wr_data = plru_touch(plru_cur, tlb_lk_way);
                    state_next   = IDLE;
                end else begin
                    state_next = WALK_REQ;
                end
            end
            WALK_REQ: begin
                ptw_req_valid = 1'b1;
                if (ptw_req_ready) begin
                    state_next = WALK_WAIT;
                end
            end
            WALK_WAIT: begin
                if (ptw_resp_valid) begin
                    state_next = ptw_resp_fault ? IDLE : FILL;
                end
            end
            FILL: begin
                tlb_fill_valid = 1'b1;
                plru_wr_en     = 1'b1;
                plru_wr_data   = plru_touch(plru_cur, victim_way);
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, arbitration pointer, response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr_reg      <= '0;
            pcid_reg       <= '0;
            id_reg         <= 1'b0;
            ppn_reg        <= '0;
            rr_ptr_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_paddr_reg <= '0;
            resp_fault_reg <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // req_ready is one-hot here, so bit 1 names the winner.
                        vaddr_reg  <= req_ready[1] ? req1_vaddr : req0_vaddr;
                        pcid_reg   <= req_ready[1] ? req1_pcid  : req0_pcid;
                        id_reg     <= req_ready[1];
                        rr_ptr_reg <= ~req_ready[1];
                    end
                end
                CHECK: begin
                    if (tlb_lk_hit) begin
                        resp_valid_reg <= 1'b1;
                        resp_id_reg    <= id_reg;
                        resp_paddr_reg <= {tlb_lk_ppn, vaddr_reg[PAGE-1:0]};
                        resp_fault_reg <= 1'b0;
                    end
                end
                WALK_WAIT: begin
                    if (ptw_resp_valid) begin
                        if (ptw_resp_fault) begin
                            resp_valid_reg <= 1'b1;
                            resp_id_reg    <= id_reg;
                            resp_paddr_reg <= '0;
                            resp_fault_reg <= 1'b1;
                        end else begin
                            ppn_reg <= ptw_resp_ppn;
                        end
                    end
                end
                FILL: begin
                    resp_valid_reg <= 1'b1;
                    resp_id_reg    <= id_reg;
                    resp_paddr_reg <= {ppn_reg, vaddr_reg[PAGE-1:0]};
                    resp_fault_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The lookup, walk and fill ports all carry the latched
    // request; their strobes say when the content is meaningful.
    // ------------------------------------------------------------------
    assign resp_valid    = resp_valid_reg;
    assign resp_id       = resp_id_reg;
    assign resp_paddr    = resp_paddr_reg;
    assign resp_fault    = resp_fault_reg;

    assign tlb_lk_vpn    = vaddr_reg[ADDR-1:PAGE];
    assign tlb_lk_pcid   = pcid_reg;

    assign ptw_req_vpn   = vaddr_reg[ADDR-1:PAGE];
    assign ptw_req_pcid  = pcid_reg;

    assign tlb_fill_way  = victim_way;
    assign tlb_fill_vpn  = vaddr_reg[ADDR-1:PAGE];
    assign tlb_fill_pcid = pcid_reg;
    assign tlb_fill_ppn  = ppn_reg;

endmodule

// File: tb/tb_tlb_ctrl.sv
module tb_tlb_ctrl;

    localparam int ADDR    = 64;
    localparam int PAGE    = 12;
    localparam int PCID    = 12;
    localparam int SET_NUM = 8;
    localparam int WAY     = 8;
    localparam int VPN_W   = ADDR - PAGE;
    localparam int WAY_W   = $clog2(WAY);

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [ADDR-1:0]  req0_vaddr, req1_vaddr;
    logic [PCID-1:0]  req0_pcid, req1_pcid;
    logic             resp_valid, resp_id, resp_fault;
    logic [ADDR-1:0]  resp_paddr;
    logic             tlb_lk_valid;
    logic [VPN_W-1:0] tlb_lk_vpn;
    logic [PCID-1:0]  tlb_lk_pcid;
    logic             tlb_lk_hit;
    logic [WAY_W-1:0] tlb_lk_way;
    logic [VPN_W-1:0] tlb_lk_ppn;
    logic             tlb_fill_valid;
    logic [WAY_W-1:0] tlb_fill_way;
    logic [VPN_W-1:0] tlb_fill_vpn;
    logic [PCID-1:0]  tlb_fill_pcid;
    logic [VPN_W-1:0] tlb_fill_ppn;
    logic             ptw_req_valid;
    logic             ptw_req_ready;
    logic [VPN_W-1:0] ptw_req_vpn;
    logic [PCID-1:0]  ptw_req_pcid;
    logic             ptw_resp_valid;
    logic [VPN_W-1:0] ptw_resp_ppn;
    logic             ptw_resp_fault;

    tlb_ctrl #(
        .ADDR(ADDR), .PAGE(PAGE), .PCID(PCID), .SET_NUM(SET_NUM), .WAY(WAY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_vaddr(req0_vaddr), .req1_vaddr(req1_vaddr),
        .req0_pcid(req0_pcid), .req1_pcid(req1_pcid),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_paddr(resp_paddr), .resp_fault(resp_fault),
        .tlb_lk_valid(tlb_lk_valid), .tlb_lk_vpn(tlb_lk_vpn), .tlb_lk_pcid(tlb_lk_pcid),
        .tlb_lk_hit(tlb_lk_hit), .tlb_lk_way(tlb_lk_way), .tlb_lk_ppn(tlb_lk_ppn),
        .tlb_fill_valid(tlb_fill_valid), .tlb_fill_way(tlb_fill_way),
        .tlb_fill_vpn(tlb_fill_vpn), .tlb_fill_pcid(tlb_fill_pcid), .tlb_fill_ppn(tlb_fill_ppn),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
        .ptw_req_vpn(ptw_req_vpn), .ptw_req_pcid(ptw_req_pcid),
        .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn),
        .ptw_resp_fault(ptw_resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn_num = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: PLRU trees as heap arrays of direction bits,
    // victim found by descending, access recorded by climbing leaf->root.
    // ------------------------------------------------------------------
    int m_plru [SET_NUM][WAY-1];
    int m_rr;

    task automatic m_reset();
        for (int s = 0; s < SET_NUM; s++)
            for (int n = 0; n < WAY - 1; n++)
                m_plru[s][n] = 0;
        m_rr = 0;
    endtask

    function automatic int m_victim(input int s);
        int node = 0;
        while (node < WAY - 1)
            node = 2 * node + 1 + m_plru[s][node];
        return node - (WAY - 1);
    endfunction

    task automatic m_touch(input int s, input int w);
        int leaf = w + WAY - 1;
        int parent;
        while (leaf > 0) begin
            parent = (leaf - 1) / 2;
            // accessed child on the left -> victim now lies to the right
            m_plru[s][parent] = (leaf == 2 * parent + 1) ? 1 : 0;
            leaf = parent;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        tick();
        rst_n = 1'b1;
    endtask

    // One full translation from offer to response.
    task automatic do_txn(input logic [1:0] mask,
                          input logic [63:0] va0, input logic [11:0] pc0,
                          input logic [63:0] va1, input logic [11:0] pc1,
                          input logic hit, input int hway, input logic [51:0] hppn,
                          input int rdy_dly, input int walk_dly,
                          input logic wfault, input logic [51:0] wppn,
                          input logic abort);
        int win, s, v;
        logic [63:0] va;
        logic [11:0] pc;
        logic [1:0]  exp_rdy;
        logic [63:0] exp_pa;

        txn_num++;
        win     = (mask == 2'b11) ? m_rr : ((mask == 2'b10) ? 1 : 0);
        va      = win ? va1 : va0;
        pc      = win ? pc1 : pc0;
        exp_rdy = win ? 2'b10 : 2'b01;
        s       = int'(va[14:12]);

        req_valid  = mask;
        req0_vaddr = va0; req0_pcid = pc0;
        req1_vaddr = va1; req1_pcid = pc1;
        #1;
        check("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
        tick();
        req_valid = 2'b00;
        m_rr = 1 - win;

        // LOOKUP
        check("lk_valid", {63'd0, tlb_lk_valid}, 64'd1);
        check("lk_vpn", {12'd0, tlb_lk_vpn}, {12'd0, va[63:12]});
        check("lk_pcid", {52'd0, tlb_lk_pcid}, {52'd0, pc});
        check("busy_ready", {62'd0, req_ready}, 64'd0);
        tick();

        // CHECK
        check("lk_pulse", {63'd0, tlb_lk_valid}, 64'd0);
        check("no_early_resp", {63'd0, resp_valid}, 64'd0);
        tlb_lk_hit = hit;
        tlb_lk_way = WAY_W'(hway);
        tlb_lk_ppn = hppn;
        tick();
        tlb_lk_hit = 1'b0;

        if (hit) begin
            m_touch(s, hway);
            exp_pa = {hppn, va[11:0]};
            check("hit_resp_valid", {63'd0, resp_valid}, 64'd1);
            check("hit_resp_id", {63'd0, resp_id}, 64'(win));
            check("hit_paddr", resp_paddr, exp_pa);
            check("hit_fault", {63'd0, resp_fault}, 64'd0);
            $display("txn %0d port %0d va=0x%0h HIT way %0d -> pa=0x%0h", txn_num, win, va, hway, exp_pa);
            return;
        end

        // WALK_REQ, walker stalls for rdy_dly cycles
        for (int i = 0; i < rdy_dly; i++) begin
            check("ptw_valid_held", {63'd0, ptw_req_valid}, 64'd1);
            check("ptw_vpn_held", {12'd0, ptw_req_vpn}, {12'd0, va[63:12]});
            tick();
        end
        check("ptw_valid", {63'd0, ptw_req_valid}, 64'd1);
        check("ptw_vpn", {12'd0, ptw_req_vpn}, {12'd0, va[63:12]});
        check("ptw_pcid", {52'd0, ptw_req_pcid}, {52'd0, pc});
        ptw_req_ready = 1'b1;
        tick();
        ptw_req_ready = 1'b0;

        // WALK_WAIT
        check("ptw_valid_drop", {63'd0, ptw_req_valid}, 64'd0);
        for (int i = 0; i < walk_dly; i++) begin
            check("wait_no_resp", {63'd0, resp_valid}, 64'd0);
            tick();
        end

        if (abort) begin
            do_reset();
            // reset released #1 after an edge: this is the first cycle out of reset
            check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
            check("rst_ptw_valid", {63'd0, ptw_req_valid}, 64'd0);
            req_valid = 2'b01;
            #1;
            check("rst_ready_first", {62'd0, req_ready}, 64'd1);
            req_valid = 2'b00;
            ptw_resp_valid = 1'b1;
            ptw_resp_fault = 1'b0;
            ptw_resp_ppn   = wppn;
            tick();
            ptw_resp_valid = 1'b0;
            check("late_walk_fill", {63'd0, tlb_fill_valid}, 64'd0);
            check("late_walk_resp", {63'd0, resp_valid}, 64'd0);
            tick();
            check("late_walk_resp2", {63'd0, resp_valid}, 64'd0);
            $display("txn %0d port %0d va=0x%0h ABORTED by reset", txn_num, win, va);
            return;
        end

        ptw_resp_valid = 1'b1;
        ptw_resp_fault = wfault;
        ptw_resp_ppn   = wppn;
        tick();
        ptw_resp_valid = 1'b0;
        ptw_resp_fault = 1'b0;

        if (wfault) begin
            check("flt_resp_valid", {63'd0, resp_valid}, 64'd1);
            check("flt_resp_id", {63'd0, resp_id}, 64'(win));
            check("flt_paddr", resp_paddr, 64'd0);
            check("flt_fault", {63'd0, resp_fault}, 64'd1);
            check("flt_no_fill", {63'd0, tlb_fill_valid}, 64'd0);
            $display("txn %0d port %0d va=0x%0h WALK FAULT", txn_num, win, va);
            return;
        end

        // FILL
        v = m_victim(s);
        check("fill_valid", {63'd0, tlb_fill_valid}, 64'd1);
        check("fill_way", {61'd0, tlb_fill_way}, 64'(v));
        check("fill_vpn", {12'd0, tlb_fill_vpn}, {12'd0, va[63:12]});
        check("fill_pcid", {52'd0, tlb_fill_pcid}, {52'd0, pc});
        check("fill_ppn", {12'd0, tlb_fill_ppn}, {12'd0, wppn});
        check("fill_no_resp", {63'd0, resp_valid}, 64'd0);
        m_touch(s, v);
        tick();

        exp_pa = {wppn, va[11:0]};
        check("fill_pulse", {63'd0, tlb_fill_valid}, 64'd0);
        check("walk_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("walk_resp_id", {63'd0, resp_id}, 64'(win));
        check("walk_paddr", resp_paddr, exp_pa);
        check("walk_fault", {63'd0, resp_fault}, 64'd0);
        $display("txn %0d port %0d va=0x%0h MISS fill way %0d -> pa=0x%0h", txn_num, win, va, v, exp_pa);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] va0, va1;
        logic [51:0] p1, p2;
        logic [1:0]  mask;

        rst_n = 1'b0;
        req_valid = 2'b00;
        req0_vaddr = '0; req1_vaddr = '0;
        req0_pcid = '0;  req1_pcid = '0;
        tlb_lk_hit = 1'b0; tlb_lk_way = '0; tlb_lk_ppn = '0;
        ptw_req_ready = 1'b0;
        ptw_resp_valid = 1'b0; ptw_resp_ppn = '0; ptw_resp_fault = 1'b0;
        m_reset();
        tick();
        tick();

        // Reset values
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_paddr", resp_paddr, 64'd0);
        check("rst_lk_valid", {63'd0, tlb_lk_valid}, 64'd0);
        check("rst_ptw_valid", {63'd0, ptw_req_valid}, 64'd0);
        check("rst_fill_valid", {63'd0, tlb_fill_valid}, 64'd0);
        check("rst_fill_way", {61'd0, tlb_fill_way}, 64'd0);
        check("rst_lk_vpn", {12'd0, tlb_lk_vpn}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic hit: 0x401234 pcid 5, way 3, ppn 0xABCDE
        do_txn(2'b01, 64'h0000_0000_0040_1234, 12'd5, 64'd0, 12'd0,
               1'b1, 3, 52'hABCDE, 0, 0, 1'b0, 52'd0, 1'b0);
        check("plan_paddr", resp_paddr, 64'hABCDE234);

        // Both ports valid, all hits: grants alternate starting at port 0
        do_reset();
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, 64'h1000 * i, 12'd1, 64'h2_0000 + 64'h1000 * i, 12'd2,
                   1'b1, i, 52'(i + 1), 0, 0, 1'b0, 52'd0, 1'b0);

        // Misses on set 1: victims 0, then 4, then 2
        do_reset();
        do_txn(2'b01, 64'h1000, 12'd7, 64'd0, 12'd0,
               1'b0, 0, 52'd0, 4, 2, 1'b0, 52'h777, 1'b0);
        check("plan_miss_paddr", resp_paddr, 64'h777000);
        do_txn(2'b10, 64'd0, 12'd0, 64'h9000, 12'd7,
               1'b0, 0, 52'd0, 0, 1, 1'b0, 52'h888, 1'b0);
        do_txn(2'b01, 64'h11000, 12'd7, 64'd0, 12'd0,
               1'b0, 0, 52'd0, 1, 0, 1'b0, 52'h999, 1'b0);

        // Walk fault leaves PLRU untouched
        do_reset();
        do_txn(2'b01, 64'h3abc, 12'd9, 64'd0, 12'd0,
               1'b0, 0, 52'd0, 0, 3, 1'b1, 52'h123, 1'b0);
        do_txn(2'b01, 64'hb000, 12'd9, 64'd0, 12'd0,
               1'b0, 0, 52'd0, 0, 0, 1'b0, 52'h456, 1'b0);

        // Reset during WALK_WAIT, late walker response ignored
        do_reset();
        do_txn(2'b01, 64'h5000, 12'd3, 64'd0, 12'd0,
               1'b0, 0, 52'd0, 1, 2, 1'b0, 52'h321, 1'b1);
        do_txn(2'b01, 64'h5000, 12'd3, 64'd0, 12'd0,
               1'b0, 0, 52'd0, 0, 0, 1'b0, 52'h654, 1'b0);

        // Hit on set 2 way 0, then miss on set 2 and a miss on set 5
        do_reset();
        do_txn(2'b01, 64'h2000, 12'd4, 64'd0, 12'd0,
               1'b1, 0, 52'h42, 0, 0, 1'b0, 52'd0, 1'b0);
        do_txn(2'b01, 64'ha000, 12'd4, 64'd0, 12'd0,
               1'b0, 0, 52'd0, 0, 0, 1'b0, 52'h43, 1'b0);
        do_txn(2'b10, 64'd0, 12'd0, 64'h5000, 12'd4,
               1'b0, 0, 52'd0, 0, 0, 1'b0, 52'h44, 1'b0);

        // Randomized traffic; model carries PLRU and pointer across everything
        for (int i = 0; i < 250; i++) begin
            mask = 2'($urandom_range(1, 3));
            va0  = {$urandom, $urandom};
            va1  = {$urandom, $urandom};
            p1   = 52'({$urandom, $urandom});
            p2   = 52'({$urandom, $urandom});
            do_txn(mask, va0, 12'($urandom), va1, 12'($urandom),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, WAY - 1)), p1,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), p2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
- Sequencer and arbiter in front of the set-associative TLB array.
- Shares the single TLB lookup/fill port between two translation requesters: port 0 (instruction side) and port 1 (data side).
- Drives a lookup; on a miss, issues a page-walk request, then fills the TLB using a per-set tree-PLRU victim.
- Returns the physical address, or a fault, to the requester that won arbitration.

Parameters:
- addr, 64, virtual/physical address width in bits.
- page, 12, page-offset width in bits.
- pcid, 12, process-context ID width in bits.
- set_num, 8, number of TLB sets; must be a power of 2.
- way, 8, ways per set; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i is port i.
- req_ready  out  2  per-port accept.
- req0_vaddr / req1_vaddr  in  addr  virtual address per port.
- req0_pcid / req1_pcid  in  pcid  PCID per port.
- resp_valid  out  1  one-cycle response pulse.
- resp_id  out  1  port that owns the response.
- resp_paddr  out  addr  physical address; 0 when resp_fault=1.
- resp_fault  out  1  walk reported a fault.
- tlb_lk_valid  out  1  lookup strobe.
- tlb_lk_vpn  out  addr-page  looked-up VPN.
- tlb_lk_pcid  out  pcid  looked-up PCID.
- tlb_lk_hit  in  1  lookup result, valid 1 cycle after tlb_lk_valid.
- tlb_lk_way  in  $clog2(way)  hit way, same timing as tlb_lk_hit.
- tlb_lk_ppn  in  addr-page  hit PPN, same timing as tlb_lk_hit.
- tlb_fill_valid  out  1  fill strobe.
- tlb_fill_way  out  $clog2(way)  victim way.
- tlb_fill_vpn  out  addr-page  fill VPN.
- tlb_fill_pcid  out  pcid  fill PCID.
- tlb_fill_ppn  out  addr-page  fill PPN.
- ptw_req_valid  out  1  walk request valid.
- ptw_req_ready  in  1  walker accepts the request.
- ptw_req_vpn  out  addr-page  VPN to walk.
- ptw_req_pcid  out  pcid  PCID to walk.
- ptw_resp_valid  in  1  walk result pulse.
- ptw_resp_ppn  in  addr-page  walked PPN.
- ptw_resp_fault  in  1  walk fault.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; every output 0.
  - All PLRU bits 0.
  - Round-robin pointer favours port 0.
  - Latched request registers 0.
- FSM states: IDLE, LOOKUP, CHECK, WALK_REQ, WALK_WAIT, FILL.
- IDLE:
  - req_ready[i] = (state==IDLE) && grant[i]; combinational, at most one bit set.
  - Grant is round-robin: with both ports valid, the pointer port wins; after any grant the pointer moves to the other port.
  - On handshake, latch vaddr, pcid and id; go to LOOKUP.
- LOOKUP:
  - tlb_lk_valid=1 for exactly 1 cycle, with vpn=vaddr[addr-1:page] and the latched pcid.
  - Go to CHECK.
- CHECK (sample tlb_lk_*):
  - Hit: update PLRU of set s toward way tlb_lk_way; register response {tlb_lk_ppn, vaddr[page-1:0]}, fault=0; go to IDLE.
  - Miss: go to WALK_REQ.
- WALK_REQ:
  - ptw_req_valid=1 with stable vpn/pcid until ptw_req_ready=1 in the same cycle.
  - Then go to WALK_WAIT.
- WALK_WAIT:
  - Wait for ptw_resp_valid; ptw_resp_valid is ignored in every other state.
  - Fault: response paddr=0, fault=1; no fill; PLRU unchanged; go to IDLE.
  - Otherwise latch ppn; go to FILL.
- FILL:
  - tlb_fill_valid=1 for 1 cycle, with tlb_fill_way = PLRU victim of set s.
  - Mark the victim as MRU.
  - Register response {ppn, offset}, fault=0; go to IDLE.
- Set index: s = vaddr[page+$clog2(set_num)-1:page].
- Response timing:
  - resp_valid pulses in the cycle after CHECK (hit) or after WALK_WAIT/FILL (fault/fill).
  - Hit latency from the accept edge is 3 cycles.
  - No backpressure on responses.
  - A new request can be accepted in the same cycle as resp_valid.
- PLRU structure:
  - way-1 bits per set, heap-indexed: node n has children 2n+1 and 2n+2.
  - Bit=0 means the victim lies in the lower half; bit=1 means the upper half.
  - Victim is found by traversing from node 0.
  - Access update sets each node on the path to point away from the accessed way.
- Requester rule: vaddr/pcid are held stable while valid && !ready. Deasserting an un-granted request is legal.
- Reset mid-operation: abort immediately to IDLE; no response is emitted for the aborted request; a walker response arriving later is ignored.
- Only one translation is in flight; no hit-under-miss.

Test Plan:
- Reset, then port 0 requests vaddr=0x0000_0000_0040_1234, pcid=5; tlb_lk_hit=1, way=3, ppn=0xABCDE -> tlb_lk_vpn=0x401 in the cycle after accept; resp_valid 3 cycles after accept with id=0, paddr=0xABCDE234, fault=0.
- Both ports valid from reset, all hits -> grants alternate 0,1,0,1; req_ready never has 2 bits set.
- Miss on set 1 (vaddr=0x1000), ptw_req_ready held 0 for 4 cycles, walker returns ppn=0x777 -> ptw_req_valid held 5 cycles with stable vpn=0x1; tlb_fill_way=0; paddr=0x777000. A second miss on set 1 fills way 4; a third fills way 2.
- Walk fault -> resp_fault=1, paddr=0, no tlb_fill_valid; the next miss on the same set still fills way 0.
- rst_n pulsed low during WALK_WAIT, then ptw_resp_valid arrives -> no resp_valid, no fill, req_ready available in the first cycle after reset release.
- Hit on set 2 way 0, then a miss on set 2 -> fill way 4; fills on other sets are unaffected (fill way 0).
